// File: rtl/cmd_dispatch_queue_if.sv
// Host push port and engine dispatch port of the command front-end.
// Both ports use valid/ready: a transfer happens on a clock edge where valid && ready are both high.
interface cmd_dispatch_queue_if #(
    parameter int CMD_W  = 64,
    parameter int ADDR_W = 48
);
    logic              in_valid;
    logic [CMD_W-1:0]  in_data;
    logic              in_ready;
    logic              out_valid;
    logic [7:0]        out_opcode;
    logic [3:0]        out_slot;
    logic [ADDR_W-1:0] out_addr;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_slot, out_addr
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_opcode, out_slot, out_addr
    );
endinterface

// File: rtl/cmd_dispatch_queue.sv
// Command FIFO plus decode/dispatch FSM for the NTT engine; HALT and FENCE are consumed here.
// Valid/ready on both ports: the producer holds valid and payload until it sees ready on an edge.
module cmd_dispatch_queue #(
    parameter int         CMD_W     = 64,
    parameter int         ADDR_W    = 48,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] OPC_HALT  = 8'h00,
    parameter logic [7:0] OPC_FENCE = 8'hFF
) (
    input  logic                         clk,
    input  logic                         rst,
    cmd_dispatch_queue_if.slave          bus,
    input  logic                         engine_busy,
    input  logic                         resume,
    output logic                         halted,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [31:0]                  dispatched_cnt,
    output logic [1:0]                   state_dbg
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_DISPATCH = 2'd1,
        S_FENCE    = 2'd2,
        S_HALTED   = 2'd3
    } state_t;

    state_t           state;
    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CMD_W-1:0] head;
    logic [7:0]       head_opc;
    logic             push;
    logic             pop;
    logic             handshake;

    assign bus.in_ready = (count < CNT_W'(DEPTH)) && !rst;
    assign push         = bus.in_valid && bus.in_ready;
    assign handshake    = bus.out_valid && bus.out_ready;
    assign head         = mem[rd_ptr];
    assign head_opc     = head[CMD_W-1 -: 8];
    // A pop in S_DISPATCH only on the handshake edge keeps back-to-back commands at one per cycle.
    assign pop          = (count != '0) &&
                          ((state == S_FETCH) || ((state == S_DISPATCH) && handshake));
    assign fifo_count   = count;
    assign state_dbg    = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_FETCH;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_opcode <= '0;
            bus.out_slot   <= '0;
            bus.out_addr   <= '0;
            halted         <= 1'b0;
            dispatched_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (handshake) begin
                dispatched_cnt <= dispatched_cnt + 32'd1;
            end

            if (pop) begin
                bus.out_valid <= 1'b0;
                if (head_opc == OPC_HALT) begin
                    state  <= S_HALTED;
                    halted <= 1'b1;
                end else if (head_opc == OPC_FENCE) begin
                    state <= S_FENCE;
                end else begin
                    state          <= S_DISPATCH;
                    bus.out_valid  <= 1'b1;
                    bus.out_opcode <= head_opc;
                    bus.out_slot   <= head[CMD_W-9 -: 4];
                    bus.out_addr   <= head[ADDR_W-1:0];
                end
            end else begin
                case (state)
                    S_DISPATCH: begin
                        if (handshake) begin
                            bus.out_valid <= 1'b0;
                            state         <= S_FETCH;
                        end
                    end
                    S_FENCE: begin
                        if (!engine_busy) begin
                            state <= S_FETCH;
                        end
                    end
                    S_HALTED: begin
                        if (resume) begin
                            halted <= 1'b0;
                            state  <= S_FETCH;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule
